pdl_ctl: RTL and testbench
==========================

Name: pdl_ctl

Overview:
Initiator side of the PDL buffer interface. It owns the PDL pointer and PDL index registers and accepts push, pop, indexed and load requests from microcode decode over a valid/ready handshake. It drives the buffer's address, read-strobe, write-strobe and write-data lines, and returns read data from the buffer with a response pulse. It sits between the microinstruction decode/L-bus logic and the 1024x32 PDL buffer RAM.

Parameters:
ADDR_WIDTH, 10, PDL address width; buffer depth is 2**ADDR_WIDTH.
DATA_WIDTH, 32, PDL word width.

Ports:
clk  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  controller can accept a request
req_op  in  3  operation code, see Behaviour
req_data  in  DATA_WIDTH  write data for PUSH/WRITE_IDX
req_ob  in  ADDR_WIDTH  load value for LOAD_PTR/LOAD_IDX
pdla  out  ADDR_WIDTH  buffer address
prp  out  1  buffer read strobe
pwp  out  1  buffer write strobe
pdl_l  out  DATA_WIDTH  buffer write data
pdlo  in  DATA_WIDTH  buffer read data (registered in buffer, valid the cycle after prp)
resp_valid  out  1  one-cycle pulse, resp_data valid
resp_data  out  DATA_WIDTH  read result
pdlptr  out  ADDR_WIDTH  current pointer
pdlidx  out  ADDR_WIDTH  current index

Behaviour:
- Reset (async assert, sync release): state IDLE; pdlptr=0, pdlidx=0, pdla=0, prp=0, pwp=0, pdl_l=0, resp_valid=0, resp_data=0, req_ready=1.
- Opcodes: 0 NOP, 1 PUSH, 2 POP, 3 READ_IDX, 4 WRITE_IDX, 5 READ_PTR, 6 LOAD_PTR, 7 LOAD_IDX.
- Accept at cycle N when req_valid & req_ready. req_ready = (state==IDLE).
- FSM: IDLE -> ACCESS for ops 1-5; ACCESS -> RESP for reads (2,3,5), ACCESS -> IDLE for writes (1,4); RESP -> IDLE. NOP, LOAD_PTR and LOAD_IDX stay in IDLE.
- ACCESS (cycle N+1): pdla, prp/pwp, pdl_l are registered outputs, exactly one strobe high for one cycle.
  - PUSH: pdla = pdlptr+1, pwp=1, pdl_l=req_data, pdlptr <= pdlptr+1.
  - POP: pdla = pdlptr, prp=1, pdlptr <= pdlptr-1.
  - READ_IDX: pdla = pdlidx, prp=1. WRITE_IDX: pdla = pdlidx, pwp=1, pdl_l=req_data.
  - READ_PTR: pdla = pdlptr, prp=1; pointer unchanged.
  - pdlptr/pdlidx updates are visible at N+1.
- RESP (cycle N+2): resp_valid=1, resp_data=pdlo (registered capture on exit), held until next read response.
- LOAD_PTR/LOAD_IDX: register takes req_ob[ADDR_WIDTH-1:0] at N+1; no strobe; req_ready stays 1.
- Arithmetic is modulo 2**ADDR_WIDTH: PUSH at 1023 writes address 0; POP at 0 leaves pdlptr=1023.
- Strobes are mutually exclusive; prp/pwp low outside ACCESS; pdla holds last value.
- Throughput: write ops one per 2 cycles, read ops one per 3 cycles, loads one per cycle.
- req_valid while busy is ignored; no queuing.
- Async reset mid-ACCESS or mid-RESP aborts the operation, clears the strobes immediately and suppresses resp_valid.

Optional Feature:
PDL_BOUNDS_EN. When defined, adds an occupancy counter (0..2**ADDR_WIDTH) and outputs pdl_ovf and pdl_unf, both sticky and cleared only by reset. PUSH at full sets pdl_ovf, POP at empty sets pdl_unf; the access still proceeds with wrap. LOAD_PTR sets occupancy = req_ob. When undefined, the counter and flags are absent.

Decomposition:
- Shared package pdl_pkg: op-code localparams, FSM state encoding, default ADDR_WIDTH/DATA_WIDTH.
- One sub-module: pdl_addr_gen, combinational next-pdla / next-pdlptr selection from op, pdlptr and pdlidx.

Test Plan:
- Reset, then PUSH data=0xDEADBEEF -> N+1: pwp=1, pdla=1, pdl_l=0xDEADBEEF, pdlptr=1; req_ready back high at N+2.
- PUSH 0x11, 0x22, then POP twice with buffer model -> resp_data 0x22 then 0x11 at N+2 of each pop; pdlptr ends at 0.
- LOAD_IDX ob=0x155, WRITE_IDX 0xA5A5A5A5, READ_IDX -> pdla=0x155 on both strobes, resp_data=0xA5A5A5A5; pdlptr unchanged.
- LOAD_PTR ob=0x3FF, PUSH 0x7 -> pdla=0x000, pdlptr=0; POP -> pdla=0, pdlptr=0x3FF.
- req_valid held high with back-to-back POP, POP -> second accepted only when req_ready returns (3-cycle spacing); reset_n pulsed during ACCESS -> prp drops at once, no resp_valid.
- With PDL_BOUNDS_EN, POP after reset -> pdl_unf=1 and it stays set; 1025 PUSHes -> pdl_ovf=1.

Source files
------------

// File: rtl/pdl_pkg.sv
// Shared definitions for the PDL buffer controller: opcodes, FSM states, default widths.
package pdl_pkg;

   localparam int unsigned ADDR_WIDTH_DEF = 10;
   localparam int unsigned DATA_WIDTH_DEF = 32;
   localparam int unsigned OP_WIDTH       = 3;

   localparam logic [OP_WIDTH-1:0] OP_NOP       = 3'd0;
   localparam logic [OP_WIDTH-1:0] OP_PUSH      = 3'd1;
   localparam logic [OP_WIDTH-1:0] OP_POP       = 3'd2;
   localparam logic [OP_WIDTH-1:0] OP_READ_IDX  = 3'd3;
   localparam logic [OP_WIDTH-1:0] OP_WRITE_IDX = 3'd4;
   localparam logic [OP_WIDTH-1:0] OP_READ_PTR  = 3'd5;
   localparam logic [OP_WIDTH-1:0] OP_LOAD_PTR  = 3'd6;
   localparam logic [OP_WIDTH-1:0] OP_LOAD_IDX  = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_e;

   function automatic logic op_is_read(input logic [OP_WIDTH-1:0] op);
      return (op == OP_POP) || (op == OP_READ_IDX) || (op == OP_READ_PTR);
   endfunction

   function automatic logic op_is_write(input logic [OP_WIDTH-1:0] op);
      return (op == OP_PUSH) || (op == OP_WRITE_IDX);
   endfunction

   function automatic logic op_is_access(input logic [OP_WIDTH-1:0] op);
      return op_is_read(op) || op_is_write(op);
   endfunction

endpackage : pdl_pkg

// File: rtl/pdl_addr_gen.sv
// Combinational next-address / next-pointer / next-index selection for one PDL request.
module pdl_addr_gen
   import pdl_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
   input  logic [OP_WIDTH-1:0]   op,
   input  logic [ADDR_WIDTH-1:0] ptr,
   input  logic [ADDR_WIDTH-1:0] idx,
   input  logic [ADDR_WIDTH-1:0] ob,
   output logic [ADDR_WIDTH-1:0] pdla_c,
   output logic [ADDR_WIDTH-1:0] ptr_c,
   output logic [ADDR_WIDTH-1:0] idx_c,
   output logic                  rd_c,
   output logic                  wr_c
);

   // Pointer arithmetic wraps naturally at the address width.
   always_comb begin : sel_comb
      pdla_c = ptr;
      ptr_c  = ptr;
      idx_c  = idx;
      rd_c   = 1'b0;
      wr_c   = 1'b0;
      case (op)
         OP_PUSH: begin
            pdla_c = ptr + ADDR_WIDTH'(1);
            ptr_c  = ptr + ADDR_WIDTH'(1);
            wr_c   = 1'b1;
         end
         OP_POP: begin
            pdla_c = ptr;
            ptr_c  = ptr - ADDR_WIDTH'(1);
            rd_c   = 1'b1;
         end
         OP_READ_IDX: begin
            pdla_c = idx;
            rd_c   = 1'b1;
         end
         OP_WRITE_IDX: begin
            pdla_c = idx;
            wr_c   = 1'b1;
         end
         OP_READ_PTR: begin
            pdla_c = ptr;
            rd_c   = 1'b1;
         end
         OP_LOAD_PTR: ptr_c = ob;
         OP_LOAD_IDX: idx_c = ob;
         default: ;
      endcase
   end

endmodule : pdl_addr_gen

// File: rtl/pdl_ctl.sv
// PDL buffer initiator: owns pdlptr/pdlidx, runs push/pop/indexed/load requests against the PDL RAM.
// Optional PDL_BOUNDS_EN adds an occupancy counter with sticky pdl_ovf / pdl_unf flags.
module pdl_ctl
   import pdl_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [OP_WIDTH-1:0]   req_op,
   input  logic [DATA_WIDTH-1:0] req_data,
   input  logic [ADDR_WIDTH-1:0] req_ob,
   output logic [ADDR_WIDTH-1:0] pdla,
   output logic                  prp,
   output logic                  pwp,
   output logic [DATA_WIDTH-1:0] pdl_l,
   input  logic [DATA_WIDTH-1:0] pdlo,
   output logic                  resp_valid,
   output logic [DATA_WIDTH-1:0] resp_data,
   output logic [ADDR_WIDTH-1:0] pdlptr,
   output logic [ADDR_WIDTH-1:0] pdlidx
`ifdef PDL_BOUNDS_EN
   ,
   output logic                  pdl_ovf,
   output logic                  pdl_unf
`endif
);

   state_e                state_q;
   state_e                state_d;
   logic [OP_WIDTH-1:0]   op_q;
   logic [OP_WIDTH-1:0]   op_d;
   logic [DATA_WIDTH-1:0] resp_hold;
   logic [DATA_WIDTH-1:0] hold_d;
   logic [ADDR_WIDTH-1:0] pdla_d;
   logic [ADDR_WIDTH-1:0] ptr_d;
   logic [ADDR_WIDTH-1:0] idx_d;
   logic [DATA_WIDTH-1:0] pdl_l_d;
   logic                  prp_d;
   logic                  pwp_d;
   logic                  resp_valid_d;
   logic                  ready_d;
   logic                  accept;

   logic [ADDR_WIDTH-1:0] ag_pdla;
   logic [ADDR_WIDTH-1:0] ag_ptr;
   logic [ADDR_WIDTH-1:0] ag_idx;
   logic                  ag_rd;
   logic                  ag_wr;

`ifdef PDL_BOUNDS_EN
   localparam int unsigned        OCC_W    = ADDR_WIDTH + 1;
   localparam logic [OCC_W-1:0]   OCC_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};
   logic [OCC_W-1:0] occ_q;
   logic [OCC_W-1:0] occ_d;
   logic             ovf_d;
   logic             unf_d;
`endif

   assign accept = req_valid & req_ready;

   pdl_addr_gen #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_addr_gen (
      .op     (req_op),
      .ptr    (pdlptr),
      .idx    (pdlidx),
      .ob     (req_ob),
      .pdla_c (ag_pdla),
      .ptr_c  (ag_ptr),
      .idx_c  (ag_idx),
      .rd_c   (ag_rd),
      .wr_c   (ag_wr)
   );

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // Next-state logic
   always_comb begin : next_state_comb
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (accept && op_is_access(req_op)) state_d = ST_ACCESS;
         ST_ACCESS: state_d = op_is_read(op_q) ? ST_RESP : ST_IDLE;
         ST_RESP:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Next values for all registered outputs and datapath state
   always_comb begin : output_comb
      pdla_d       = pdla;
      prp_d        = 1'b0;
      pwp_d        = 1'b0;
      pdl_l_d      = pdl_l;
      ptr_d        = pdlptr;
      idx_d        = pdlidx;
      resp_valid_d = 1'b0;
      hold_d       = resp_hold;
      op_d         = op_q;
      ready_d      = (state_d == ST_IDLE);
`ifdef PDL_BOUNDS_EN
      occ_d        = occ_q;
      ovf_d        = pdl_ovf;
      unf_d        = pdl_unf;
`endif
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               op_d  = req_op;
               ptr_d = ag_ptr;
               idx_d = ag_idx;
               prp_d = ag_rd;
               pwp_d = ag_wr;
               if (ag_rd || ag_wr) pdla_d  = ag_pdla;
               if (ag_wr)          pdl_l_d = req_data;
`ifdef PDL_BOUNDS_EN
               case (req_op)
                  OP_PUSH: begin
                     if (occ_q == OCC_FULL) ovf_d = 1'b1;
                     else                   occ_d = occ_q + OCC_W'(1);
                  end
                  OP_POP: begin
                     if (occ_q == '0) unf_d = 1'b1;
                     else             occ_d = occ_q - OCC_W'(1);
                  end
                  OP_LOAD_PTR: occ_d = {1'b0, req_ob};
                  default: ;
               endcase
`endif
            end
         end
         ST_ACCESS: resp_valid_d = op_is_read(op_q);
         ST_RESP:   hold_d = pdlo;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pdla       <= '0;
         prp        <= 1'b0;
         pwp        <= 1'b0;
         pdl_l      <= '0;
         pdlptr     <= '0;
         pdlidx     <= '0;
         resp_valid <= 1'b0;
         resp_hold  <= '0;
         req_ready  <= 1'b1;
         op_q       <= OP_NOP;
`ifdef PDL_BOUNDS_EN
         occ_q      <= '0;
         pdl_ovf    <= 1'b0;
         pdl_unf    <= 1'b0;
`endif
      end else begin
         pdla       <= pdla_d;
         prp        <= prp_d;
         pwp        <= pwp_d;
         pdl_l      <= pdl_l_d;
         pdlptr     <= ptr_d;
         pdlidx     <= idx_d;
         resp_valid <= resp_valid_d;
         resp_hold  <= hold_d;
         req_ready  <= ready_d;
         op_q       <= op_d;
`ifdef PDL_BOUNDS_EN
         occ_q      <= occ_d;
         pdl_ovf    <= ovf_d;
         pdl_unf    <= unf_d;
`endif
      end
   end

   // pdlo is already a registered RAM output; pass it through during RESP, then hold the capture.
   assign resp_data = (state_q == ST_RESP) ? pdlo : resp_hold;

endmodule : pdl_ctl

// File: tb/tb_pdl_ctl.sv
// Bench for pdl_ctl: directed scenarios plus random request stream against a stack/array model.
module tb_pdl_ctl;
   import pdl_pkg::*;

   localparam int unsigned AW    = 10;
   localparam int unsigned DW    = 32;
   localparam int unsigned DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [2:0]    req_op = 3'd0;
   logic [DW-1:0] req_data = '0;
   logic [AW-1:0] req_ob = '0;
   logic [AW-1:0] pdla;
   logic          prp;
   logic          pwp;
   logic [DW-1:0] pdl_l;
   logic [DW-1:0] pdlo = '0;
   logic          resp_valid;
   logic [DW-1:0] resp_data;
   logic [AW-1:0] pdlptr;
   logic [AW-1:0] pdlidx;
`ifdef PDL_BOUNDS_EN
   logic          pdl_ovf;
   logic          pdl_unf;
`endif

   pdl_ctl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_data   (req_data),
      .req_ob     (req_ob),
      .pdla       (pdla),
      .prp        (prp),
      .pwp        (pwp),
      .pdl_l      (pdl_l),
      .pdlo       (pdlo),
      .resp_valid (resp_valid),
      .resp_data  (resp_data),
      .pdlptr     (pdlptr),
      .pdlidx     (pdlidx)
`ifdef PDL_BOUNDS_EN
      ,
      .pdl_ovf    (pdl_ovf),
      .pdl_unf    (pdl_unf)
`endif
   );

   always #5 clk = ~clk;

   // PDL RAM the controller talks to (registered read port)
   logic [DW-1:0] ram [DEPTH];
   always @(posedge clk) begin
      if (pwp) ram[pdla] <= pdl_l;
      if (prp) pdlo <= ram[pdla];
   end

   // Reference model state
   logic [DW-1:0] ref_mem [DEPTH];
   int            ref_ptr;
   int            ref_idx;
   int            ref_pdla;
   logic [DW-1:0] ref_hold;
   int            ref_occ;
   logic          ref_ovf;
   logic          ref_unf;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
   endtask

   task automatic model_reset();
      ref_ptr  = 0;
      ref_idx  = 0;
      ref_pdla = 0;
      ref_hold = '0;
      ref_occ  = 0;
      ref_ovf  = 1'b0;
      ref_unf  = 1'b0;
   endtask

   task automatic apply_reset();
      req_valid = 1'b0;
      reset_n   = 1'b0;
      repeat (2) @(negedge clk);
      reset_n   = 1'b1;
      model_reset();
   endtask

   task automatic chk_bounds();
`ifdef PDL_BOUNDS_EN
      chk("pdl_ovf", 64'(pdl_ovf), 64'(ref_ovf));
      chk("pdl_unf", 64'(pdl_unf), 64'(ref_unf));
`endif
   endtask

   // Issue one request at a negedge with the controller idle; returns at the negedge it is idle again.
   task automatic do_op(input logic [2:0] op, input logic [DW-1:0] data, input logic [AW-1:0] ob);
      int            e_addr;
      logic          e_rd;
      logic          e_wr;
      logic [DW-1:0] e_rdata;
      chk("ready_idle", 64'(req_ready), 64'(1));
      req_valid = 1'b1;
      req_op    = op;
      req_data  = data;
      req_ob    = ob;
      e_rd   = 1'b0;
      e_wr   = 1'b0;
      e_addr = ref_pdla;
      case (op)
         3'd1: begin
            if (ref_occ == int'(DEPTH)) ref_ovf = 1'b1; else ref_occ++;
            ref_ptr = (ref_ptr + 1) % DEPTH;
            e_addr  = ref_ptr;
            e_wr    = 1'b1;
         end
         3'd2: begin
            if (ref_occ == 0) ref_unf = 1'b1; else ref_occ--;
            e_addr  = ref_ptr;
            ref_ptr = (ref_ptr + DEPTH - 1) % DEPTH;
            e_rd    = 1'b1;
         end
         3'd3: begin e_addr = ref_idx; e_rd = 1'b1; end
         3'd4: begin e_addr = ref_idx; e_wr = 1'b1; end
         3'd5: begin e_addr = ref_ptr; e_rd = 1'b1; end
         3'd6: begin ref_ptr = int'(ob); ref_occ = int'(ob); end
         3'd7: ref_idx = int'(ob);
         default: ;
      endcase
      if (e_wr) ref_mem[e_addr] = data;
      e_rdata = ref_mem[e_addr];

      @(negedge clk);
      if (e_rd || e_wr) begin
         // Requests presented while busy must be ignored
         req_valid = 1'($urandom_range(0, 1));
         req_op    = 3'($urandom_range(0, 7));
         req_data  = $urandom;
         req_ob    = AW'($urandom_range(0, DEPTH - 1));
      end else begin
         req_valid = 1'b0;
      end
      chk("pdlptr", 64'(pdlptr), 64'(ref_ptr));
      chk("pdlidx", 64'(pdlidx), 64'(ref_idx));
      chk("prp", 64'(prp), 64'(e_rd));
      chk("pwp", 64'(pwp), 64'(e_wr));
      chk("resp_valid_n1", 64'(resp_valid), 64'(0));
      if (e_rd || e_wr) begin
         ref_pdla = e_addr;
         chk("pdla", 64'(pdla), 64'(e_addr));
         chk("ready_busy", 64'(req_ready), 64'(0));
         if (e_wr) chk("pdl_l", 64'(pdl_l), 64'(data));
      end else begin
         chk("pdla_hold", 64'(pdla), 64'(ref_pdla));
         chk("ready_load", 64'(req_ready), 64'(1));
         chk("resp_data_hold", 64'(resp_data), 64'(ref_hold));
      end

      if (e_wr) begin
         @(negedge clk);
         req_valid = 1'b0;
         chk("wr_strobe_off", 64'({prp, pwp}), 64'(0));
         chk("wr_ready_back", 64'(req_ready), 64'(1));
         chk("wr_no_resp", 64'(resp_valid), 64'(0));
      end
      if (e_rd) begin
         @(negedge clk);
         chk("rd_strobe_off", 64'({prp, pwp}), 64'(0));
         chk("resp_valid", 64'(resp_valid), 64'(1));
         chk("resp_data", 64'(resp_data), 64'(e_rdata));
         chk("rd_ready_resp", 64'(req_ready), 64'(0));
         @(negedge clk);
         req_valid = 1'b0;
         ref_hold  = e_rdata;
         chk("resp_pulse_end", 64'(resp_valid), 64'(0));
         chk("resp_data_held", 64'(resp_data), 64'(ref_hold));
         chk("rd_ready_back", 64'(req_ready), 64'(1));
      end
      chk_bounds();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         ram[i]     = '0;
         ref_mem[i] = '0;
      end
      model_reset();
      apply_reset();

      // Reset state
      chk("rst_pdla", 64'(pdla), 64'(0));
      chk("rst_strobes", 64'({prp, pwp}), 64'(0));
      chk("rst_pdl_l", 64'(pdl_l), 64'(0));
      chk("rst_resp", 64'({resp_valid, resp_data}), 64'(0));
      chk("rst_ptr_idx", 64'({pdlptr, pdlidx}), 64'(0));
      chk("rst_ready", 64'(req_ready), 64'(1));

      do_op(3'd1, 32'hDEADBEEF, '0);
      chk("push_ptr_1", 64'(pdlptr), 64'(1));

      // Stack order
      apply_reset();
      do_op(3'd1, 32'h11, '0);
      do_op(3'd1, 32'h22, '0);
      do_op(3'd2, '0, '0);
      chk("pop1_data", 64'(resp_data), 64'(32'h22));
      do_op(3'd2, '0, '0);
      chk("pop2_data", 64'(resp_data), 64'(32'h11));
      chk("ptr_end", 64'(pdlptr), 64'(0));

      // Indexed access
      do_op(3'd7, '0, 10'h155);
      do_op(3'd4, 32'hA5A5A5A5, '0);
      do_op(3'd3, '0, '0);
      chk("idx_rd_data", 64'(resp_data), 64'(32'hA5A5A5A5));
      chk("idx_ptr_same", 64'(pdlptr), 64'(0));

      // Pointer wrap both directions
      do_op(3'd6, '0, 10'h3FF);
      do_op(3'd1, 32'h7, '0);
      chk("wrap_ptr0", 64'(pdlptr), 64'(0));
      do_op(3'd2, '0, '0);
      chk("wrap_ptr3ff", 64'(pdlptr), 64'(10'h3FF));
      chk("wrap_pop_data", 64'(resp_data), 64'(32'h7));

      // Back-to-back POPs with req_valid held: second accepted on ready's return
      p0 = ref_ptr;
      req_valid = 1'b1;
      req_op    = 3'd2;
      @(negedge clk);
      chk("b2b_prp1", 64'(prp), 64'(1));
      chk("b2b_pdla1", 64'(pdla), 64'(p0));
      chk("b2b_ready1", 64'(req_ready), 64'(0));
      @(negedge clk);
      chk("b2b_resp1", 64'(resp_valid), 64'(1));
      chk("b2b_data1", 64'(resp_data), 64'(ref_mem[p0]));
      chk("b2b_no_accept", 64'(prp), 64'(0));
      @(negedge clk);
      chk("b2b_ready2", 64'(req_ready), 64'(1));
      chk("b2b_idle_prp", 64'(prp), 64'(0));
      @(negedge clk);
      req_valid = 1'b0;
      chk("b2b_prp2", 64'(prp), 64'(1));
      chk("b2b_pdla2", 64'(pdla), 64'((p0 + DEPTH - 1) % DEPTH));
      @(negedge clk);
      chk("b2b_data2", 64'(resp_data), 64'(ref_mem[(p0 + DEPTH - 1) % DEPTH]));
      ref_hold = ref_mem[(p0 + DEPTH - 1) % DEPTH];
      ref_pdla = (p0 + DEPTH - 1) % DEPTH;
      ref_ptr  = (p0 + DEPTH - 2) % DEPTH;
      if (ref_occ > 0) ref_occ--; else ref_unf = 1'b1;
      if (ref_occ > 0) ref_occ--; else ref_unf = 1'b1;
      @(negedge clk);
      chk("b2b_ptr", 64'(pdlptr), 64'(ref_ptr));

      // Async reset during ACCESS aborts the read
      req_valid = 1'b1;
      req_op    = 3'd5;
      @(negedge clk);
      req_valid = 1'b0;
      chk("abort_prp_pre", 64'(prp), 64'(1));
      #2 reset_n = 1'b0;
      #1;
      chk("abort_prp_now", 64'(prp), 64'(0));
      chk("abort_ptr", 64'(pdlptr), 64'(0));
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("abort_no_resp", 64'(resp_valid), 64'(0));
      end
      chk("abort_ready", 64'(req_ready), 64'(1));

      // Random request stream
      for (int i = 0; i < 400; i++)
         do_op(3'($urandom_range(0, 7)), $urandom, AW'($urandom_range(0, DEPTH - 1)));

`ifdef PDL_BOUNDS_EN
      apply_reset();
      do_op(3'd2, '0, '0);
      chk("unf_set", 64'(pdl_unf), 64'(1));
      for (int i = 0; i < int'(DEPTH) + 1; i++)
         do_op(3'd1, $urandom, '0);
      chk("ovf_set", 64'(pdl_ovf), 64'(1));
      chk("unf_sticky", 64'(pdl_unf), 64'(1));
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule : tb_pdl_ctl
